uart_tx_serializer: RTL
=======================

Name: uart_tx_serializer

Overview:
- Transmit-side counterpart to the team's flex_counter-based serial receive path.
- Accepts a parallel data word through a ready/valid-style handshake.
- Frames the word as start bit, data bits LSB-first, optional even parity bit, then stop bit.
- Drives each bit on a single serial line for a programmable number of clock cycles, timed by an internal bit-period counter with rollover detection.

Parameters:
- NUM_DATA_BITS, 8, number of data bits per frame (legal range 5–9).
- NUM_CNT_BITS, 4, width of the bit-period counter and of the bit_period port.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset; all registers return to reset values on any clk rising edge where rst=1.
- tx_data  input  NUM_DATA_BITS  word to transmit; sampled only on the accept edge.
- tx_start  input  1  request to transmit tx_data.
- bit_period  input  NUM_CNT_BITS  clock cycles per serial bit; sampled on the accept edge; value 0 is treated as 1.
- parity_en  input  1  when 1, an even-parity bit is inserted; sampled on the accept edge.
- tx_ready  output  1  block is idle and will accept tx_start.
- tx_busy  output  1  a frame is in progress.
- tx_done  output  1  one-cycle pulse marking frame completion.
- tx_out  output  1  serial line; idles high.

Behaviour:
- Timing convention: edge 0 is the accept edge; cycle k is the interval following edge k-1.
- Reset values:
  - tx_out=1, tx_busy=0, tx_done=0, tx_ready=1.
  - FSM=IDLE, counters=0, shift register=0.
- Reset mid-frame: frame is aborted; tx_out=1 and IDLE from the cycle after the reset edge; no tx_done.
- FSM states:
  - IDLE: tx_ready=1, tx_out=1.
  - START: tx_out=0.
  - DATA: tx_out=shift[0].
  - PARITY: tx_out=XOR of the latched word.
  - STOP: tx_out=1.
- Accept: on an edge where state=IDLE and tx_start=1 (and rst=0):
  - latch tx_data, bit_period (P, with 0 mapped to 1) and parity_en;
  - go to START; tx_out becomes 0 and tx_busy=1 in cycle 1.
  - tx_start outside IDLE is ignored; there is no queuing.
- Bit timing:
  - The period counter counts 1..P; it clears and advances the FSM on the edge where count==P.
  - Every bit lasts exactly P cycles.
- DATA state:
  - Shift register shifts right once per bit.
  - A bit index 0..NUM_DATA_BITS-1 selects DATA→PARITY (parity_en=1) or DATA→STOP (parity_en=0) after the last bit.
- STOP→IDLE at the end of the stop bit. In the first IDLE cycle: tx_done=1 for exactly one cycle, tx_busy=0, tx_ready=1.
- Frame length: F = (NUM_DATA_BITS + 2 + parity_en) × P cycles. The start bit occupies cycles 1..P and the stop bit occupies cycles F-P+1..F. tx_done is high in cycle F+1.
- Back-to-back: tx_start=1 during the tx_done cycle is accepted at that edge. The next start bit begins in cycle F+2, giving exactly one idle-high cycle between frames.
- Outputs tx_out, tx_done and tx_busy are registered (glitch-free). tx_ready is decoded from state==IDLE.
- Changes on tx_data, bit_period or parity_en during a frame have no effect.

Test Plan:
- Reset, then idle 10 cycles with tx_start=0 → tx_out=1, tx_ready=1, tx_busy=0, tx_done=0 throughout.
- P=4, parity_en=0, tx_data=0xA5, 1-cycle tx_start:
  - tx_out=0 in cycles 1–4;
  - data bits 1,0,1,0,0,1,0,1 in 4-cycle groups over cycles 5–36;
  - stop bit 1 in cycles 37–40;
  - tx_done=1 only in cycle 41.
- P=2, parity_en=1, tx_data=0x07:
  - parity bit=1 in cycles 19–20;
  - stop bit in cycles 21–22;
  - tx_done in cycle 23.
- P=0 (treated as 1), tx_data=0xFF, tx_start held high for 2 frames:
  - first frame is 10 cycles, tx_done in cycle 11;
  - second start bit in cycle 12;
  - second tx_done in cycle 22.
- P=4, tx_data=0x3C, rst=1 asserted at the edge ending cycle 15:
  - tx_out=1, tx_ready=1 from cycle 16;
  - no tx_done;
  - a subsequent 0x81 frame is correct.
- During a frame, pulse tx_start and change tx_data/bit_period/parity_en → frame content and timing are unchanged; no second frame follows.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames a parallel word as start, LSB-first data,
// optional even parity and stop bit, each held for a programmable bit period.
module uart_tx_serializer #(
  parameter int NUM_DATA_BITS = 8,
  parameter int NUM_CNT_BITS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_DATA_BITS-1:0] tx_data,
  input  logic                     tx_start,
  input  logic [NUM_CNT_BITS-1:0]  bit_period,
  input  logic                     parity_en,
  output logic                     tx_ready,
  output logic                     tx_busy,
  output logic                     tx_done,
  output logic                     tx_out,
  output logic [2:0]               state_o
);

  // Handshake: tx_ready is high exactly while IDLE; a frame is accepted on any
  // rising edge where tx_ready=1 and tx_start=1. tx_start at other times is dropped.

  localparam int IDX_W = (NUM_DATA_BITS > 1) ? $clog2(NUM_DATA_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [NUM_CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [NUM_CNT_BITS-1:0]  period_q, period_d;
  logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     par_en_q, par_en_d;
  logic                     parity_q, parity_d;
  logic                     tx_out_q, tx_out_d;
  logic                     tx_busy_q, tx_busy_d;
  logic                     tx_done_q, tx_done_d;
  logic                     roll;

  assign roll = (cnt_q == period_q);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      shift_q   <= '0;
      idx_q     <= '0;
      par_en_q  <= 1'b0;
      parity_q  <= 1'b0;
      tx_out_q  <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      par_en_q  <= par_en_d;
      parity_q  <= parity_d;
      tx_out_q  <= tx_out_d;
      tx_busy_q <= tx_busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  // Next-state: the period counter runs 1..P and reloads 1 on rollover so every bit is P cycles
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    par_en_d = par_en_q;
    parity_d = parity_q;
    if (state_q == IDLE) begin
      if (tx_start) begin
        state_d  = START;
        cnt_d    = NUM_CNT_BITS'(1);
        period_d = (bit_period == '0) ? NUM_CNT_BITS'(1) : bit_period;
        shift_d  = tx_data;
        idx_d    = '0;
        par_en_d = parity_en;
        parity_d = ^tx_data;
      end
    end else if (!roll) begin
      cnt_d = cnt_q + NUM_CNT_BITS'(1);
    end else begin
      cnt_d = NUM_CNT_BITS'(1);
      case (state_q)
        START: state_d = DATA;
        DATA: begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_W'(NUM_DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        PARITY: state_d = STOP;
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are computed from the next state so the registered line is aligned with it
  always_comb begin
    tx_out_d = 1'b1;
    case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[0];
      PARITY:  tx_out_d = parity_d;
      default: tx_out_d = 1'b1;
    endcase
    tx_busy_d = (state_d != IDLE);
    tx_done_d = (state_q == STOP) && roll;
  end

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;
  assign tx_out   = tx_out_q;
  assign state_o  = state_q;

endmodule
